cordic_share_arbiter: RTL and testbench
=======================================

# cordic_share_arbiter

Shares one fully pipelined CORDIC core between two requesters, e.g. two custom-instruction ports or a CPU and a DMA engine. Arbitrates one issue per cycle and tracks every in-flight operation through the core's fixed latency. Routes each core result back to the requester that issued it, in issue order. Sits between the requesters' single-precision float operands (dataa) and the CORDIC core's dataa/result ports.

## Interface
- LAT, 16: core latency in cycles; core_result for an operand sampled at the end of cycle c is valid during cycle c+LAT; LAT ≥ 1.
- MAX_OUT, 4: maximum outstanding operations per requester; 1..LAT+1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand.
- req0_dataa  in  32  requester 0 operand (IEEE-754 single).
- req0_ready  out  1  requester 0 operand is accepted this cycle.
- rsp0_valid  out  1  one-cycle pulse: rsp0_result is valid.
- rsp0_result  out  32  result for requester 0.
- req1_valid, req1_dataa, req1_ready, rsp1_valid, rsp1_result: same as requester 0, for requester 1.
- core_dataa  out  32  operand to the CORDIC core.
- core_result  in  32  result from the CORDIC core.
- busy  out  1  at least one operation is in flight.

## Operation
- Handshake: a transfer occurs when reqN_valid && reqN_ready in the same cycle. reqN_ready is combinational from the valids, the outstanding counts and the arbitration state. Requesters hold valid/dataa stable until accepted.
- Eligibility: requester N is eligible when reqN_valid = 1 and its outstanding count is below MAX_OUT.
- Grant: at most one ready per cycle.
  - One eligible requester: it is granted.
  - Both eligible: round-robin; grant the requester not granted last.
  - The last-grant pointer updates only on a transfer.
- core_dataa = granted requester's dataa in a transfer cycle; 32'h0 otherwise.
- Tracking: LAT-stage shift register of {valid, tag}. Stage 0 loads {transfer, granted index} each cycle; stage LAT-1 feeds response capture.
- Response: when stage LAT-1 is valid, register core_result into rspT_result and pulse rspT_valid for one cycle, where T is the tag.
  - rsp*_result holds its value between pulses.
  - Responses have no back-pressure; requesters must accept every pulse.
- Outstanding count per requester, width clog2(MAX_OUT+1): +1 on that requester's transfer, −1 on its response. Both in the same cycle leaves the count unchanged.
- busy = OR of all tracking-stage valids and any transfer this cycle.
- Ordering: responses to each requester return in issue order. Responses to different requesters never collide, since one issue per cycle gives one response per cycle.

## Timing
- Latency: handshake in cycle c, then rspN_valid in cycle c+LAT+1 (LAT+1 cycles).
- Throughput: one operation per cycle, aggregate over both requesters.
- Reset (rst = 0 at a rising edge), all values valid from the next cycle:
  - rsp0/1_valid = 0, rsp0/1_result = 0, req0/1_ready = 0, busy = 0, core_dataa = 0.
  - All tracking stages invalid; outstanding counts = 0.
  - Last-grant pointer = 1, so requester 0 wins the first contention.
- Reset mid-operation: in-flight operations are discarded and no response is ever produced for them. Stale core_result values are ignored.
- While rst = 0, no grants are issued regardless of the valids.
- Count at MAX_OUT with a response in the same cycle: the requester stays ineligible that cycle; the count frees next cycle.

## Configuration
- CORDIC_ARB_FIXED_PRIO_EN defined: fixed priority; requester 0 always wins contention; the last-grant pointer is removed.
- Not defined: round-robin as described above.

## Test plan
The bench core model is a LAT-deep delay line, so core_result equals the operand delayed; use LAT = 16 and MAX_OUT = 4.
- Single issue: req0 0xBF060A92 accepted in cycle 5 -> rsp0_valid in cycle 22 only, rsp0_result = 0xBF060A92; rsp1_valid never asserted; busy high cycles 5-21.
- Contention: both requesters valid continuously, req0 = 0x3E860A92, req1 = 0x3F060A92, from reset release -> grants alternate 0,1,0,1; responses alternate with matching data, each LAT+1 cycles after its grant.
- Outstanding limit: req1 valid with 8 distinct operands -> exactly 4 accepted back-to-back; req1_ready low until the first rsp1_valid; the fifth operand is accepted the cycle after that pulse.
- Reset mid-flight: 3 operations issued, rst low for 1 cycle 5 cycles later -> no rsp pulses follow; counts 0; the next single req0 completes in LAT+1 cycles.
- Idle data: no valids -> core_dataa = 0x00000000, busy = 0, no responses.
- With CORDIC_ARB_FIXED_PRIO_EN: both valid, MAX_OUT = 4 -> req0 gets 4 consecutive grants, then req1 is granted while req0 is blocked at its limit.

Source files
------------

// File: rtl/cordic_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter_if
// Bundles the two requester handshakes and the CORDIC core data path that the
// arbiter sits between.
//   req0/1_valid, req0/1_dataa : requester operand offer (held until ready)
//   req0/1_ready               : operand accepted this cycle
//   rsp0/1_valid, rsp0/1_result: one-cycle result pulse, result held between
//   core_dataa / core_result   : operand to / result from the pipelined core
//   busy                       : at least one operation in flight
// Modports: slave = arbiter side, master = requester/core side.
// -----------------------------------------------------------------------------
interface cordic_share_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_dataa;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_result;
  logic        req1_valid;
  logic [31:0] req1_dataa;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_result;
  logic [31:0] core_dataa;
  logic [31:0] core_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_dataa, req1_valid, req1_dataa, core_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output core_dataa, busy
  );

  modport master (
    output req0_valid, req0_dataa, req1_valid, req1_dataa, core_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  core_dataa, busy
  );
endinterface

// File: rtl/cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter
// Shares one fully pipelined CORDIC core (latency LAT) between two requesters.
// One operand is issued per cycle; each issue is tracked through a LAT-deep
// {valid, tag} shift register so the core result is routed back to the
// requester that issued it, in issue order.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : cordic_share_arbiter_if.slave (requester handshakes, core path, busy)
//
// Parameters:
//   LAT     : core latency in cycles (>= 1)
//   MAX_OUT : maximum outstanding operations per requester (1..LAT+1)
//
// Configuration macro:
//   CORDIC_ARB_FIXED_PRIO_EN : when defined, requester 0 always wins contention
//                              and the last-grant pointer is removed; otherwise
//                              contention is resolved round-robin.
// -----------------------------------------------------------------------------
module cordic_share_arbiter #(
  parameter int LAT     = 16,
  parameter int MAX_OUT = 4
) (
  input logic                   clk,
  input logic                   rst,
  cordic_share_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  // Requester signals gathered into arrays so per-requester logic is generated.
  logic        req_valid [2];
  logic [31:0] req_dataa [2];
  logic        elig      [2];
  logic [1:0]  grant;
  logic        transfer;
  logic        grant_idx;

  logic [CW-1:0] cnt_reg        [2];
  logic          rsp_valid_reg  [2];
  logic [31:0]   rsp_result_reg [2];

  logic stg_valid_reg [LAT];
  logic stg_tag_reg   [LAT];
  logic stg_any;

  assign req_valid[0] = bus.req0_valid;
  assign req_valid[1] = bus.req1_valid;
  assign req_dataa[0] = bus.req0_dataa;
  assign req_dataa[1] = bus.req1_dataa;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifndef CORDIC_ARB_FIXED_PRIO_EN
  // Index of the requester granted on the most recent transfer.
  logic last_reg;
`endif

  always_comb begin
    grant = 2'b00;
    // No grants while reset is asserted, whatever the valids say.
    if (rst) begin
      if (elig[0] && elig[1]) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_reg ? 2'b01 : 2'b10;
`endif
      end else if (elig[0]) begin
        grant = 2'b01;
      end else if (elig[1]) begin
        grant = 2'b10;
      end
    end
  end

  assign transfer  = grant[0] | grant[1];
  assign grant_idx = grant[1];

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg <= 1'b1;   // requester 0 wins the first contention
    end else if (transfer) begin
      last_reg <= grant_idx;
    end
  end
`endif

  assign bus.core_dataa = grant[0] ? req_dataa[0] :
                          grant[1] ? req_dataa[1] : 32'h0;

  // ---------------------------------------------------------------------------
  // Per-requester eligibility, outstanding count and response capture
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      // The count only drops after the response pulse has been seen, so a
      // requester at its limit stays blocked through the pulse cycle.
      assign elig[gi] = req_valid[gi] && (cnt_reg[gi] < CW'(MAX_OUT));

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else begin
          case ({grant[gi], rsp_valid_reg[gi]})
            2'b10:   cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            2'b01:   cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            default: cnt_reg[gi] <= cnt_reg[gi];
          endcase
        end
      end

      // Last tracking stage lines up with the core result for that issue.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rsp_valid_reg[gi]  <= 1'b0;
          rsp_result_reg[gi] <= 32'h0;
        end else begin
          rsp_valid_reg[gi] <= stg_valid_reg[LAT-1] && (stg_tag_reg[LAT-1] == 1'(gi));
          if (stg_valid_reg[LAT-1] && (stg_tag_reg[LAT-1] == 1'(gi))) begin
            rsp_result_reg[gi] <= bus.core_result;
          end
        end
      end
    end
  endgenerate

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.rsp0_valid  = rsp_valid_reg[0];
  assign bus.rsp1_valid  = rsp_valid_reg[1];
  assign bus.rsp0_result = rsp_result_reg[0];
  assign bus.rsp1_result = rsp_result_reg[1];

  // ---------------------------------------------------------------------------
  // In-flight tracking: stage k holds the issue from k+1 cycles ago
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_valid_reg[0] <= 1'b0;
      stg_tag_reg[0]   <= 1'b0;
    end else begin
      stg_valid_reg[0] <= transfer;
      stg_tag_reg[0]   <= grant_idx;
    end
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (!rst) begin
          stg_valid_reg[gi] <= 1'b0;
          stg_tag_reg[gi]   <= 1'b0;
        end else begin
          stg_valid_reg[gi] <= stg_valid_reg[gi-1];
          stg_tag_reg[gi]   <= stg_tag_reg[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    stg_any = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      stg_any = stg_any | stg_valid_reg[i];
    end
  end

  assign bus.busy = stg_any | transfer;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_share_arbiter
// Drives two requester sources from operand queues, models the core as a
// LAT-deep delay line, and predicts every output per cycle from queues of
// outstanding operations and scheduled responses.
// -----------------------------------------------------------------------------
module tb_cordic_share_arbiter;
  localparam int LAT     = 16;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_share_arbiter_if bus_if ();

  cordic_share_arbiter #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Core model: operand sampled at the end of cycle c appears during c+LAT.
  logic [31:0] core_line [LAT];
  always @(posedge clk) begin
    core_line[0] <= bus_if.core_dataa;
    for (int i = 1; i < LAT; i++) core_line[i] <= core_line[i-1];
  end
  assign bus_if.core_result = core_line[LAT-1];

  // Operand sources: valid while the queue holds something.
  logic [31:0] src0[$];
  logic [31:0] src1[$];

  // Reference state.
  int          pend0[$];          // response cycles of outstanding req0 ops
  int          pend1[$];
  int          exp_who [int];     // response cycle -> requester
  logic [31:0] exp_data[int];     // response cycle -> data
  int          last_grant  = 1;
  int          last_issue  = -1000;
  logic [31:0] hres0 = 32'h0;
  logic [31:0] hres1 = 32'h0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int grant_cyc0 = -1;
  int seen_rsp0  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    pend0.delete();
    pend1.delete();
    exp_who.delete();
    exp_data.delete();
    last_grant = 1;
    last_issue = -1000;
    hres0 = 32'h0;
    hres1 = 32'h0;
  endtask

  // One clock cycle: drive inputs, predict, compare, advance the model.
  task automatic step(input bit rst_low);
    bit e0, e1, ev0, ev1, exp_busy;
    int g;
    logic [31:0] exp_core;
    @(posedge clk);
    cyc++;
    #1;
    rst               = !rst_low;
    bus_if.req0_valid = (src0.size() > 0);
    bus_if.req0_dataa = (src0.size() > 0) ? src0[0] : 32'h0;
    bus_if.req1_valid = (src1.size() > 0);
    bus_if.req1_dataa = (src1.size() > 0) ? src1[0] : 32'h0;
    #1;
    // An outstanding op frees its slot the cycle after its response pulse.
    while (pend0.size() > 0 && pend0[0] < cyc) void'(pend0.pop_front());
    while (pend1.size() > 0 && pend1[0] < cyc) void'(pend1.pop_front());
    e0 = !rst_low && src0.size() > 0 && pend0.size() < MAX_OUT;
    e1 = !rst_low && src1.size() > 0 && pend1.size() < MAX_OUT;
    g = -1;
    if (e0 && e1) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (last_grant == 0) ? 1 : 0;
`endif
    end else if (e0) g = 0;
    else if (e1) g = 1;

    exp_core = (g == 0) ? src0[0] : (g == 1) ? src1[0] : 32'h0;
    exp_busy = (g >= 0) || ((cyc - last_issue) >= 1 && (cyc - last_issue) <= LAT);
    ev0 = exp_who.exists(cyc) && exp_who[cyc] == 0;
    ev1 = exp_who.exists(cyc) && exp_who[cyc] == 1;
    if (ev0) hres0 = exp_data[cyc];
    if (ev1) hres1 = exp_data[cyc];

    check("req0_ready",  {31'h0, bus_if.req0_ready}, {31'h0, g == 0});
    check("req1_ready",  {31'h0, bus_if.req1_ready}, {31'h0, g == 1});
    check("core_dataa",  bus_if.core_dataa, exp_core);
    check("busy",        {31'h0, bus_if.busy}, {31'h0, exp_busy});
    check("rsp0_valid",  {31'h0, bus_if.rsp0_valid}, {31'h0, ev0});
    check("rsp1_valid",  {31'h0, bus_if.rsp1_valid}, {31'h0, ev1});
    check("rsp0_result", bus_if.rsp0_result, hres0);
    check("rsp1_result", bus_if.rsp1_result, hres1);

    if (bus_if.rsp0_valid === 1'b1) seen_rsp0 = cyc;
    if (ev0) $display("cycle %0d rsp0 data=%h", cyc, hres0);
    if (ev1) $display("cycle %0d rsp1 data=%h", cyc, hres1);

    if (g >= 0) begin
      $display("cycle %0d grant req%0d data=%h", cyc, g, exp_core);
      exp_who[cyc + LAT + 1]  = g;
      exp_data[cyc + LAT + 1] = exp_core;
      last_grant = g;
      last_issue = cyc;
      if (g == 0) begin
        pend0.push_back(cyc + LAT + 1);
        void'(src0.pop_front());
        grant_cyc0 = cyc;
      end else begin
        pend1.push_back(cyc + LAT + 1);
        void'(src1.pop_front());
      end
    end
    if (rst_low) clear_model();
  endtask

  initial begin
    bus_if.req0_valid = 1'b0;
    bus_if.req0_dataa = 32'h0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_dataa = 32'h0;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Idle: nothing valid, core_dataa and busy stay zero.
    repeat (6) step(1'b0);

    // Single issue from requester 0; response exactly LAT+1 cycles later.
    src0.push_back(32'hBF060A92);
    seen_rsp0 = -1;
    repeat (LAT + 6) step(1'b0);
    check("single_latency", 32'(seen_rsp0 - grant_cyc0), 32'(LAT + 1));

    // Contention: both requesters valid continuously.
    for (int i = 0; i < 12; i++) begin
      src0.push_back(32'h3E860A92);
      src1.push_back(32'h3F060A92);
    end
    for (int i = 0; i < 120 && (src0.size() + src1.size()) > 0; i++) step(1'b0);
    check("contention_drain", 32'(src0.size() + src1.size()), 32'h0);
    repeat (LAT + 4) step(1'b0);

    // Outstanding limit: eight distinct operands from requester 1 only.
    for (int i = 0; i < 8; i++) src1.push_back($urandom() ^ 32'(i));
    for (int i = 0; i < 80 && src1.size() > 0; i++) step(1'b0);
    check("limit_drain", 32'(src1.size()), 32'h0);
    repeat (LAT + 4) step(1'b0);

    // Reset mid-flight: three issues, then a one-cycle reset.
    for (int i = 0; i < 3; i++) src0.push_back($urandom());
    for (int i = 0; i < 20 && src0.size() > 0; i++) step(1'b0);
    check("flight_drain", 32'(src0.size()), 32'h0);
    repeat (4) step(1'b0);
    step(1'b1);
    repeat (LAT + 4) step(1'b0);

    // Fresh single request after the reset completes normally.
    src0.push_back(32'h3F800000);
    seen_rsp0 = -1;
    repeat (LAT + 4) step(1'b0);
    check("post_reset_latency", 32'(seen_rsp0 - grant_cyc0), 32'(LAT + 1));

    // Random traffic from both requesters.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && src0.size() < 3) src0.push_back($urandom());
      if ($urandom_range(0, 2) == 0 && src1.size() < 3) src1.push_back($urandom());
      step(1'b0);
    end
    src0.delete();
    src1.delete();
    repeat (LAT + 4) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
